// File: rtl/pe_addr_pkg.sv
// Shared widths, default depths and FSM states for the PE L1 address generator.
// Imported by pe_wrap_cnt and pe_l1_addr_gen.
package pe_addr_pkg;

  localparam int O_DEPTH_DEF  = 5;
  localparam int IW_DEPTH_DEF = 32;

  // Address width for a buffer of d entries; never below one bit.
  function automatic int addr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  localparam int O_addr_type_L1 = addr_w(O_DEPTH_DEF);
  localparam int I_addr_type_L1 = addr_w(IW_DEPTH_DEF);
  localparam int W_addr_type_L1 = addr_w(IW_DEPTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/pe_wrap_cnt.sv
// Wrapping up-counter 0..MAX with sync clear and enable.
// Ports: clk, rst, clr, en -> cnt, tc (cnt==MAX), wrap (en & tc).
module pe_wrap_cnt
  import pe_addr_pkg::*;
#(
  parameter int MAX = IW_DEPTH_DEF - 1,
  parameter int W   = I_addr_type_L1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         wrap
);

  assign tc   = (cnt == W'(MAX));
  assign wrap = en & tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pe_l1_addr_gen.sv
// L1 address generator: walks o (outer) x c (inner) as vld/rdy beats.
// Ports: start -> busy/done; beat = vld, i_addr, w_addr, o_addr, acc_clr, o_wr; rdy.
module pe_l1_addr_gen
  import pe_addr_pkg::*;
#(
  parameter int O_DEPTH  = O_DEPTH_DEF,
  parameter int IW_DEPTH = IW_DEPTH_DEF,
  localparam int OW = addr_w(O_DEPTH),
  localparam int IW = addr_w(IW_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          vld,
  input  logic          rdy,
  output logic [IW-1:0] i_addr,
  output logic [IW-1:0] w_addr,
  output logic [OW-1:0] o_addr,
  output logic          acc_clr,
  output logic          o_wr
);

  state_t state_q, state_d;

  logic          go;
  logic          xfer;
  logic [IW-1:0] c;
  logic [OW-1:0] o;
  logic          c_tc, c_wrap;
  logic          o_tc, o_wrap;
  logic [IW-1:0] c_nxt;

  assign go   = (state_q == IDLE) & start;
  assign xfer = (state_q == RUN) & vld & rdy;

  pe_wrap_cnt #(.MAX(IW_DEPTH - 1), .W(IW)) u_c (
    .clk  (clk),
    .rst  (rst),
    .clr  (go),
    .en   (xfer),
    .cnt  (c),
    .tc   (c_tc),
    .wrap (c_wrap)
  );

  // o_wrap marks the very last beat of the pass.
  pe_wrap_cnt #(.MAX(O_DEPTH - 1), .W(OW)) u_o (
    .clk  (clk),
    .rst  (rst),
    .clr  (go),
    .en   (c_wrap),
    .cnt  (o),
    .tc   (o_tc),
    .wrap (o_wrap)
  );

  assign c_nxt  = c_tc ? '0 : c + 1'b1;
  assign i_addr = c;
  assign w_addr = c;
  assign o_addr = o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = RUN;
      RUN:     if (o_wrap) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flags are registered alongside the counters so they track the
  // beat that the counters will present next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc_clr <= 1'b0;
      o_wr    <= 1'b0;
    end else begin
      vld  <= (state_d == RUN);
      busy <= (state_d == RUN);
      done <= (state_d == FIN);
      if (go) begin
        acc_clr <= 1'b1;
        o_wr    <= (IW_DEPTH == 1);
      end else if (xfer) begin
        acc_clr <= (state_d == RUN) & (c_nxt == '0);
        o_wr    <= (state_d == RUN)
                 & (c_nxt == IW'(IW_DEPTH - 1));
      end else if (state_d != RUN) begin
        acc_clr <= 1'b0;
        o_wr    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_l1_addr_gen.sv
// Randomized self-checking bench for pe_l1_addr_gen.
// Reference: beat k of a pass is o=k/IW, c=k%IW.
module tb_pe_l1_addr_gen;

  localparam int OD = 5;
  localparam int ID = 32;
  localparam int NB = OD * ID;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, rdy, busy, done, vld, acc_clr, o_wr;
  logic [4:0] i_addr, w_addr;
  logic [2:0] o_addr;

  logic start2, rdy2, busy2, done2, vld2, clr2, wr2;
  logic [0:0] i2, w2, o2;

  int checks = 0;
  int errors = 0;

  pe_l1_addr_gen dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .done(done), .vld(vld), .rdy(rdy), .i_addr(i_addr),
    .w_addr(w_addr), .o_addr(o_addr), .acc_clr(acc_clr),
    .o_wr(o_wr)
  );

  pe_l1_addr_gen #(.O_DEPTH(2), .IW_DEPTH(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2),
    .done(done2), .vld(vld2), .rdy(rdy2), .i_addr(i2),
    .w_addr(w2), .o_addr(o2), .acc_clr(clr2), .o_wr(wr2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_vld"}, vld, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_clr"}, acc_clr, 0);
    chk({pfx, "_wr"}, o_wr, 0);
    chk({pfx, "_i"}, i_addr, 0);
    chk({pfx, "_w"}, w_addr, 0);
    chk({pfx, "_o"}, o_addr, 0);
  endtask

  // duty: rdy percentage; restart_at: beat to re-pulse start;
  // stall_last: cycles rdy=0 on final beat; abort_at: beat to reset.
  task automatic run_pass(input int duty, input int restart_at,
                          input int stall_last, input int abort_at,
                          input bit timed);
    int k = 0;
    int cyc = 0;
    int stall = 0;
    bit prev_busy = 0;
    bit fin = 0;
    bit aborted = 0;
    @(negedge clk);
    start = 1'b1;
    rdy = 1'b0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("first_beat_vld", vld, 1);
      if (done) begin
        chk("done_beats", k, NB);
        chk("busy_at_done", busy, 0);
        chk("busy_before_done", prev_busy, 1);
        chk("vld_at_done", vld, 0);
        if (timed) chk("done_cycle", cyc, NB + 1);
        fin = 1;
      end else if (vld) begin
        chk("i_addr", i_addr, k % ID);
        chk("w_addr", w_addr, k % ID);
        chk("o_addr", o_addr, k / ID);
        chk("acc_clr", acc_clr, (k % ID) == 0);
        chk("o_wr", o_wr, (k % ID) == ID - 1);
        chk("busy", busy, 1);
        if (k == abort_at) begin
          rst = 1'b1;
          #1;
          chk_zero("abort");
          fin = 1;
          aborted = 1;
        end else begin
          rdy = ($urandom_range(0, 99) < duty);
          if (k == NB - 1 && stall < stall_last) begin
            rdy = 1'b0;
            stall++;
          end
          if (k == restart_at) start = 1'b1;
          if (rdy) k++;
        end
      end else begin
        chk("vld_in_pass", vld, 1);
      end
      prev_busy = busy;
    end
    if (!fin) chk("timeout", cyc, 0);
    if (timed) chk("first_last_cycle", 0, 0 + (cyc - (NB + 1)));
    if (stall_last > 0) chk("final_stall", stall, stall_last);
    start = 1'b0;
    if (aborted) begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk("post_abort_done", done, 0);
        chk("post_abort_vld", vld, 0);
      end
    end else begin
      repeat (3) begin
        @(negedge clk);
        rdy = $urandom_range(0, 1);
        chk("single_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_vld", vld, 0);
      end
    end
    rdy = 1'b0;
  endtask

  task automatic run_small();
    int k = 0;
    int cyc = 0;
    bit fin = 0;
    @(negedge clk);
    start2 = 1'b1;
    rdy2 = 1'b1;
    while (!fin && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start2 = 1'b0;
      if (done2) begin
        chk("small_beats", k, 2);
        chk("small_busy", busy2, 0);
        fin = 1;
      end else if (vld2) begin
        chk("small_o", o2, k);
        chk("small_i", i2, 0);
        chk("small_clr", clr2, 1);
        chk("small_wr", wr2, 1);
        k++;
      end
    end
    if (!fin) chk("small_timeout", cyc, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rdy = 1'b0;
    start2 = 1'b0;
    rdy2 = 1'b0;
    #1;
    chk_zero("reset");
    chk("reset_vld2", vld2, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_vld", vld, 0);

    run_pass(100, -1, 0, -1, 1'b1);
    run_pass(30, -1, 0, -1, 1'b0);
    run_pass(60, 50, 0, -1, 1'b0);
    run_pass(100, -1, 0, 77, 1'b0);
    run_pass(100, -1, 0, -1, 1'b1);
    run_pass(100, -1, 10, -1, 1'b0);
    run_small();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_l1_addr_gen.md
PE_L1_ADDR_GEN -- requirements
Module: pe_l1_addr_gen

Interface
REQ-001 The block SHALL have parameter O_DEPTH, default 5, number of L1 output-buffer entries (outer loop bound).
REQ-002 The block SHALL have parameter IW_DEPTH, default 32, number of L1 input/weight-buffer entries (inner loop bound).
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle request to begin a pass.
REQ-006 The block SHALL have port busy, output, 1, high from accepted start until the final beat is consumed.
REQ-007 The block SHALL have port done, output, 1, one-cycle pulse after the final beat is consumed.
REQ-008 The block SHALL have port vld, output, 1, address beat valid.
REQ-009 The block SHALL have port rdy, input, 1, downstream PE input port accepts the beat.
REQ-010 The block SHALL have port i_addr, output, clog2(IW_DEPTH) (5), L1 input-buffer address.
REQ-011 The block SHALL have port w_addr, output, clog2(IW_DEPTH) (5), L1 weight-buffer address.
REQ-012 The block SHALL have port o_addr, output, clog2(O_DEPTH) (3), L1 output-buffer address.
REQ-013 The block SHALL have port acc_clr, output, 1, beat is the first of an output (clear accumulator).
REQ-014 The block SHALL have port o_wr, output, 1, beat is the last of an output (write accumulator to o_addr).

Function
REQ-015 The FSM SHALL have states IDLE, RUN, FIN.
REQ-016 In IDLE, start=1 SHALL move to RUN on the next edge, with counters o=0, c=0 and vld=1.
REQ-017 In RUN, vld SHALL stay 1 and the beat SHALL be i_addr=c, w_addr=c, o_addr=o, acc_clr=(c==0), o_wr=(c==IW_DEPTH-1).
REQ-018 A beat SHALL transfer only on a cycle with vld&rdy=1.
REQ-019 After a transfer, c SHALL increment; at c==IW_DEPTH-1 it SHALL wrap to 0 and o SHALL increment.
REQ-020 A transfer at o==O_DEPTH-1 and c==IW_DEPTH-1 SHALL move the FSM to FIN, with vld=0 on the next cycle.
REQ-021 While vld=1 and rdy=0, all beat outputs SHALL hold stable; no combinational path from rdy to vld is allowed.
REQ-022 FIN SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-023 busy SHALL equal (state==RUN).
REQ-024 start SHALL be ignored in RUN and FIN.
REQ-025 A pass SHALL produce exactly O_DEPTH*IW_DEPTH beats (160 at defaults).
REQ-026 With rdy held at 1, the first beat SHALL appear in the cycle after start and the last beat 160 cycles after start; done SHALL pulse 161 cycles after start.
REQ-027 When IW_DEPTH=1, acc_clr and o_wr SHALL both be 1 on every beat.

Reset
REQ-028 rst=1 SHALL asynchronously force state=IDLE, o=0, c=0, and vld, busy, done, acc_clr, o_wr and all addresses to 0.
REQ-029 Reset asserted mid-pass SHALL abort the pass with no done pulse; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-030 The package pe_addr_pkg SHALL hold O_addr_type_L1, I_addr_type_L1 and W_addr_type_L1 widths, the default depths and the FSM state enum.
REQ-031 The block SHALL use one sub-module, pe_wrap_cnt: a counter with enable, terminal count and wrap flag, instantiated once for c and once for o.
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 The bench SHALL reset, pulse start with rdy=1, and check 160 beats in order (o0c0..o4c31), acc_clr on 5 beats, o_wr on 5 beats, and done at cycle 161.
REQ-034 The bench SHALL apply random rdy at 30% duty and check every beat is held stable while stalled and the transferred sequence is identical to REQ-033.
REQ-035 The bench SHALL pulse start again mid-pass at beat 50 and check the sequence is unaffected and there is a single done.
REQ-036 The bench SHALL assert rst at beat 77 with vld high and check all outputs are 0 immediately; a new start SHALL then restart from o0c0.
REQ-037 The bench SHALL hold rdy=0 during the final beat (o4c31) for 10 cycles and check done only after its transfer, with busy falling together with done's rise.
REQ-038 The bench SHALL set O_DEPTH=2 and IW_DEPTH=1, and check 2 beats, each with acc_clr=o_wr=1.
